// File: rtl/acam_fifo_readout.sv
`default_nettype none
// ============================================================================
//  Module   : acam_fifo_readout
//  Purpose  : Reader for the ACAM TDC FIFO handshake. Watches the ACAM empty
//             flag (resynchronised), produces fixed-width rd_n strobes and
//             latches each timestamp word into a single-entry valid/ready
//             output slot.
//  Ports    :
//    clk_sys_i     - system clock, single clock domain
//    rst_n_i       - synchronous active-low reset
//    enable_i      - readout enable (level)
//    acam_ef_i     - ACAM FIFO empty flag, asynchronous, 1 = empty
//    acam_rd_n_o   - ACAM read strobe, active-low, registered
//    acam_data_i   - ACAM data bus, sampled at the end of the rd_n pulse
//    ts_data_o     - latched timestamp word
//    ts_valid_o    - ts_data_o holds an unconsumed word
//    ts_ready_i    - consumer accepts word when valid and ready are both high
//    busy_o        - FSM is not idle
//    words_read_o  - completed read count, modulo 2^32
//  Revision : 1.0 - initial release
// ============================================================================
module acam_fifo_readout #(
   parameter int g_data_width         = 28,
   parameter int g_ef_sync_stages     = 2,
   parameter int g_rd_low_cycles      = 4,
   parameter int g_rd_recovery_cycles = 2
) (
   input  logic                    clk_sys_i,
   input  logic                    rst_n_i,
   input  logic                    enable_i,
   input  logic                    acam_ef_i,
   output logic                    acam_rd_n_o,
   input  logic [g_data_width-1:0] acam_data_i,
   output logic [g_data_width-1:0] ts_data_o,
   output logic                    ts_valid_o,
   input  logic                    ts_ready_i,
   output logic                    busy_o,
   output logic [31:0]             words_read_o
);

   // RECOVER spans the synchroniser latency plus the ACAM ef update time, so
   // the IDLE decision after it always sees an ef that reflects the last read.
   localparam int c_recover_cycles = g_ef_sync_stages + g_rd_recovery_cycles;
   localparam int c_cnt_max = (c_recover_cycles > g_rd_low_cycles) ?
                              c_recover_cycles : g_rd_low_cycles;
   localparam int c_cnt_w   = ($clog2(c_cnt_max) > 4) ? $clog2(c_cnt_max) : 4;

   localparam logic [c_cnt_w-1:0] c_low_last = c_cnt_w'(g_rd_low_cycles - 1);
   localparam logic [c_cnt_w-1:0] c_rec_last = c_cnt_w'(c_recover_cycles - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_LOW  = 2'd1,
      ST_RECOVER = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [g_ef_sync_stages-1:0] r_ef_sync;
   logic                    w_ef_sync;
   logic [c_cnt_w-1:0]      r_cnt;
   logic                    r_rd_n;
   logic [g_data_width-1:0] r_data;
   logic                    r_valid;
   logic [31:0]             r_words_read;
   logic                    w_slot_free;
   logic                    w_start;
   logic                    w_load;

   // ------------------------------------------------------------------------
   // Empty-flag synchroniser; reset to "empty" so nothing is read until a
   // genuine not-empty indication has propagated through all stages.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_sys_i) begin
      if (!rst_n_i) begin
         r_ef_sync <= '1;
      end else begin
         r_ef_sync <= {r_ef_sync[g_ef_sync_stages-2:0], acam_ef_i};
      end
   end

   assign w_ef_sync = r_ef_sync[g_ef_sync_stages-1];

   // Slot is free if empty now or being drained on this same edge.
   assign w_slot_free = !r_valid || ts_ready_i;

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_sys_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next-state and control strobes
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_load       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable_i && !w_ef_sync && w_slot_free) begin
               w_state_next = ST_RD_LOW;
               w_start      = 1'b1;
            end
         end
         ST_RD_LOW: begin
            // enable_i and ef are deliberately ignored: a started pulse
            // always runs to full length and its word is delivered.
            if (r_cnt == c_low_last) begin
               w_state_next = ST_RECOVER;
               w_load       = 1'b1;
            end
         end
         ST_RECOVER: begin
            if (r_cnt == c_rec_last) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: phase counter, strobe, output slot, read counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_sys_i) begin
      if (!rst_n_i) begin
         r_cnt        <= '0;
         r_rd_n       <= 1'b1;
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_words_read <= '0;
      end else begin
         // Counter restarts at every state change so each phase counts from 0.
         if ((w_state_next != r_state) || (r_state == ST_IDLE)) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + c_cnt_one;
         end

         if (w_start) begin
            r_rd_n <= 1'b0;
         end else if (w_load) begin
            r_rd_n <= 1'b1;
         end

         // A load wins over a simultaneous consume: the new word stays valid.
         if (w_load) begin
            r_data       <= acam_data_i;
            r_valid      <= 1'b1;
            r_words_read <= r_words_read + 32'd1;
         end else if (ts_ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign acam_rd_n_o  = r_rd_n;
   assign ts_data_o    = r_data;
   assign ts_valid_o   = r_valid;
   assign busy_o       = (r_state != ST_IDLE);
   assign words_read_o = r_words_read;

endmodule
`default_nettype wire

// File: doc/acam_fifo_readout.md
Name: acam_fifo_readout

Overview:
FPGA-side reader for the ACAM TDC FIFO handshake on the FMC TDC mezzanine. It watches the ACAM empty flag (ef, active-low "not empty"), generates correctly timed rd_n strobes, and latches the 28-bit timestamp word. Each word is presented on a single-entry valid/ready stream toward the TDC timestamp-processing logic. It is the initiator/reader for the ef1/rd_n responder modelled in the SVEC TDC simulation.

Parameters:
g_data_width, 28, width of ACAM data bus and output word
g_ef_sync_stages, 2, synchroniser flops on acam_ef_i (range 2..4)
g_rd_low_cycles, 4, clk_sys_i cycles rd_n is held low per read (range 1..15)
g_rd_recovery_cycles, 2, extra rd_n-high cycles after a read, on top of g_ef_sync_stages, before ef is re-sampled

Ports:
clk_sys_i  in  1  system clock, single clock domain
rst_n_i  in  1  reset, synchronous, active-low
enable_i  in  1  readout enable; level-sensitive
acam_ef_i  in  1  ACAM FIFO empty flag, asynchronous; 1 = empty
acam_rd_n_o  out  1  ACAM read strobe, active-low, registered
acam_data_i  in  g_data_width  ACAM data bus, sampled while rd_n low
ts_data_o  out  g_data_width  latched timestamp word
ts_valid_o  out  1  ts_data_o holds an unconsumed word
ts_ready_i  in  1  consumer accepts word when valid and ready high in same cycle
busy_o  out  1  high in any state other than IDLE
words_read_o  out  32  count of completed reads, wraps 0xFFFFFFFF -> 0

Behaviour:
- Reset: on rising edge with rst_n_i=0: acam_rd_n_o=1, ts_valid_o=0, ts_data_o=0, busy_o=0, words_read_o=0, FSM=IDLE, synchroniser flops loaded with 1 (empty). Applies mid-read; the rd_n pulse is truncated immediately.
- ef_sync = acam_ef_i after g_ef_sync_stages flops (S). Only ef_sync drives logic.
- FSM states: IDLE, RD_LOW, RECOVER.
- IDLE: acam_rd_n_o=1. Go RD_LOW when enable_i=1 and ef_sync=0 and output slot free. Slot free means ts_valid_o=0, or ts_ready_i=1 in the same cycle. acam_rd_n_o registers to 0 on that edge.
- RD_LOW: rd_n held low exactly g_rd_low_cycles (L) cycles, counted by a 4-bit counter. On the edge ending the last low cycle:
  - acam_data_i -> ts_data_o
  - ts_valid_o <= 1
  - words_read_o += 1
  - acam_rd_n_o <= 1
  - go RECOVER
- enable_i deassertion during RD_LOW does not shorten the pulse; the word is delivered.
- RECOVER: rd_n high for S + g_rd_recovery_cycles (R) cycles, covering ef update time plus synchroniser latency; then go IDLE. Guarantees no read on a stale ef.
- Latency: ef fall at input -> ef_sync=0 after S edges -> rd_n low on following edge. Minimum rd_n-high gap between back-to-back reads = S+R+1 cycles (RECOVER plus the IDLE decision cycle).
- Output stream:
  - ts_valid_o clears on a cycle with ts_ready_i=1 unless a new word loads on that same edge.
  - ts_data_o stays stable while ts_valid_o=1 and ts_ready_i=0.
  - Word loads only on RD_LOW exit, which can occur only when the slot was free at IDLE exit. Since valid cannot become set between IDLE exit and RD_LOW exit, no word is ever overwritten.
- Simultaneous consume and load on one edge: ts_valid_o stays 1 with the new data.
- ef_sync rising during RD_LOW is ignored; the read completes.
- Widths: all counters sized for parameter maxima; words_read_o is modulo 2^32.

Test Plan:
(S=2, L=4, R=2, ts_ready_i=1 unless stated)
1. Single word: enable=1; ef drops at cycle 0 with data 0xABCDEF1, rises 2 cycles after rd_n low -> rd_n low in cycles 3..6 exactly; ts_valid_o=1 for one cycle with ts_data_o=0xABCDEF1; words_read_o=1; busy_o low again after RECOVER (4 cycles).
2. Burst: ef held low, data 0x0000001/2/3, ef high after third rd_n -> three 4-cycle rd_n pulses separated by 5 high cycles; stream carries 1,2,3 in order; words_read_o=3.
3. Backpressure: ts_ready_i=0, ef low for 2 words -> first word 0x1234567 held stable with valid=1; no second rd_n pulse. Raise ready at cycle 50 -> word consumed, second rd_n falls next cycle.
4. Disable mid-read: enable_i drops in 2nd rd_n-low cycle -> pulse still 4 cycles, word delivered; no further reads although ef stays low.
5. Reset mid-read: rst_n_i=0 in 3rd rd_n-low cycle -> next edge rd_n=1, valid=0, words_read_o=0, busy_o=0. After release with ef low, a fresh full 4-cycle read follows.
6. Counter wrap / disabled: preload counter to 0xFFFFFFFF via forced state, one read -> 0x00000000. With enable=0 and ef low for 100 cycles -> rd_n never asserted.
